vt_escape_parser: RTL and testbench

VT_ESCAPE_PARSER -- requirements
Module: vt_escape_parser

---
 rtl/vt_escape_parser.sv | 175 +++++++++++++++++
 tb/tb_vt_escape_parser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vt_escape_parser.sv
// VT100 subset parser: 4-byte input FIFO feeding a GROUND/ESC/CSI parser with one registered command slot.
// Latency: byte strobed in cycle N appears as a command in cycle N+2. The slot holds while cmd_ready is low; bytes arriving into a full FIFO are dropped and overflow is set.
module vt_escape_parser (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_char,
  output logic [6:0] cmd_x,
  output logic [4:0] cmd_y,
  output logic       overflow
);

  typedef enum logic [1:0] {ST_GROUND, ST_ESC, ST_CSI} state_t;

  localparam logic [2:0] OP_PUT   = 3'd0;
  localparam logic [2:0] OP_CR    = 3'd1;
  localparam logic [2:0] OP_LF    = 3'd2;
  localparam logic [2:0] OP_BS    = 3'd3;
  localparam logic [2:0] OP_GOTO  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;
  localparam logic [2:0] OP_EEOL  = 3'd6;
  localparam logic [7:0] B_ESC    = 8'h1B;

  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       overflow_q;

  state_t     state_q;
  logic [7:0] p1_q, p2_q;
  logic       idx_q;
  logic       cmd_valid_q;
  logic [2:0] cmd_op_q;
  logic [7:0] cmd_char_q;
  logic [6:0] cmd_x_q;
  logic [4:0] cmd_y_q;

  logic        pop, push;
  logic [7:0]  head;
  logic        is_digit;
  logic [7:0]  p_sel, p_acc;
  logic [11:0] p_mul;
  logic [4:0]  goto_y;
  logic [6:0]  goto_x;

  assign head = fifo_q[rd_ptr_q];
  assign pop  = (count_q != 3'd0) && (!cmd_valid_q || cmd_ready);
  // A full FIFO still accepts a byte when its head leaves in the same cycle.
  assign push = rx_valid && ((count_q != 3'd4) || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  assign is_digit = (head >= 8'h30) && (head <= 8'h39);
  assign p_sel    = idx_q ? p2_q : p1_q;
  assign p_mul    = ({4'd0, p_sel} * 12'd10) + {8'd0, head[3:0]};
  assign p_acc    = (p_mul > 12'd255) ? 8'hFF : p_mul[7:0];

  // Parameter 0 means 1; rows clamp to 30, columns to 80, then convert to 0-based.
  assign goto_y = (p1_q == 8'd0) ? 5'd0 : (p1_q >= 8'd30) ? 5'd29 : (p1_q[4:0] - 5'd1);
  assign goto_x = (p2_q == 8'd0) ? 7'd0 : (p2_q >= 8'd80) ? 7'd79 : (p2_q[6:0] - 7'd1);

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
      if (rx_valid && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (push && !reset) fifo_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q     <= ST_GROUND;
      p1_q        <= 8'd0;
      p2_q        <= 8'd0;
      idx_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_PUT;
      cmd_char_q  <= 8'd0;
      cmd_x_q     <= 7'd0;
      cmd_y_q     <= 5'd0;
    end else if (pop) begin
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_PUT;
      cmd_char_q  <= 8'd0;
      cmd_x_q     <= 7'd0;
      cmd_y_q     <= 5'd0;
      unique case (state_q)
        ST_GROUND: begin
          if (head >= 8'h20 && head <= 8'h7E) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_PUT;
            cmd_char_q  <= head;
          end else if (head == 8'h0D) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_CR;
          end else if (head == 8'h0A) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_LF;
          end else if (head == 8'h08) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_BS;
          end else if (head == B_ESC) begin
            state_q <= ST_ESC;
          end
        end
        ST_ESC: begin
          if (head == 8'h5B) begin
            state_q <= ST_CSI;
            p1_q    <= 8'd0;
            p2_q    <= 8'd0;
            idx_q   <= 1'b0;
          end else if (head != B_ESC) begin
            state_q <= ST_GROUND;
          end
        end
        ST_CSI: begin
          state_q <= ST_GROUND;
          if (is_digit) begin
            state_q <= ST_CSI;
            if (idx_q) p2_q <= p_acc;
            else       p1_q <= p_acc;
          end else if (head == 8'h3B) begin
            state_q <= ST_CSI;
            idx_q   <= 1'b1;
          end else if (head == B_ESC) begin
            state_q <= ST_ESC;
          end else if (head == 8'h48 || head == 8'h66) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_GOTO;
            cmd_x_q     <= goto_x;
            cmd_y_q     <= goto_y;
          end else if (head == 8'h4A && p1_q == 8'd2) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_CLEAR;
          end else if (head == 8'h4B && p1_q == 8'd0) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_EEOL;
          end
        end
        default: state_q <= ST_GROUND;
      endcase
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_char  = cmd_char_q;
  assign cmd_x     = cmd_x_q;
  assign cmd_y     = cmd_y_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vt_escape_parser.sv
// Bench for vt_escape_parser: cycle model of FIFO plus a byte-level VT parser, compared every cycle, with directed literal checks.
module tb_vt_escape_parser;

  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] rx_data   = 8'd0;
  logic       rx_valid  = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_char;
  logic [6:0] cmd_x;
  logic [4:0] cmd_y;
  logic       overflow;

  vt_escape_parser dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_char  (cmd_char),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .overflow  (overflow)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] ch;
    logic [6:0] x;
    logic [4:0] y;
  } cmd_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned mq[$];
  bit   exp_valid = 1'b0;
  bit   exp_ovf   = 1'b0;
  cmd_t exp_cmd   = '0;
  int   m_mode    = 0;   // 0 ground, 1 after ESC, 2 inside CSI
  int   m_p[2];
  int   m_idx     = 0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void m_parse(input byte unsigned b, output bit emit, output cmd_t c);
    int row, col;
    emit = 1'b0;
    c = '0;
    case (m_mode)
      0: begin
        if (b >= 8'h20 && b <= 8'h7E) begin emit = 1; c.op = 3'd0; c.ch = b; end
        else if (b == 8'h0D) begin emit = 1; c.op = 3'd1; end
        else if (b == 8'h0A) begin emit = 1; c.op = 3'd2; end
        else if (b == 8'h08) begin emit = 1; c.op = 3'd3; end
        else if (b == 8'h1B) m_mode = 1;
      end
      1: begin
        if (b == "[") begin m_mode = 2; m_p[0] = 0; m_p[1] = 0; m_idx = 0; end
        else if (b != 8'h1B) m_mode = 0;
      end
      default: begin
        m_mode = 0;
        if (b >= "0" && b <= "9") begin
          m_mode = 2;
          m_p[m_idx] = min_i(m_p[m_idx] * 10 + (b - "0"), 255);
        end else if (b == ";") begin
          m_mode = 2;
          m_idx = 1;
        end else if (b == 8'h1B) begin
          m_mode = 1;
        end else if (b == "H" || b == "f") begin
          row = min_i((m_p[0] == 0) ? 1 : m_p[0], 30);
          col = min_i((m_p[1] == 0) ? 1 : m_p[1], 80);
          emit = 1; c.op = 3'd4; c.x = 7'(col - 1); c.y = 5'(row - 1);
        end else if (b == "J") begin
          if (m_p[0] == 2) begin emit = 1; c.op = 3'd5; end
        end else if (b == "K") begin
          if (m_p[0] == 0) begin emit = 1; c.op = 3'd6; end
        end
      end
    endcase
  endfunction

  cmd_t dut_log[$];
  bit   hold_chk = 1'b0;
  cmd_t held     = '0;

  always @(posedge clk_25mhz) begin
    bit   pop, full, emit;
    cmd_t c;
    hold_chk = !reset && cmd_valid && !cmd_ready;
    held     = {cmd_op, cmd_char, cmd_x, cmd_y};
    if (!reset && cmd_valid && cmd_ready) dut_log.push_back({cmd_op, cmd_char, cmd_x, cmd_y});
    if (reset) begin
      mq.delete();
      exp_valid = 0; exp_ovf = 0; exp_cmd = '0;
      m_mode = 0; m_p[0] = 0; m_p[1] = 0; m_idx = 0;
    end else begin
      full = (mq.size() == 4);
      pop  = (mq.size() > 0) && (!exp_valid || cmd_ready);
      if (pop) begin
        m_parse(mq.pop_front(), emit, c);
        exp_valid = emit;
        if (emit) exp_cmd = c;
      end else if (exp_valid && cmd_ready) begin
        exp_valid = 0;
      end
      if (rx_valid) begin
        if (!full || pop) mq.push_back(rx_data);
        else exp_ovf = 1;
      end
    end
  end

  always @(negedge clk_25mhz) begin
    check("cmd_valid", 32'(cmd_valid), 32'(exp_valid));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    if (exp_valid) check("cmd_fields", 32'({cmd_op, cmd_char, cmd_x, cmd_y}), 32'(exp_cmd));
    if (hold_chk) check("hold_stable", 32'({cmd_op, cmd_char, cmd_x, cmd_y}), 32'(held));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk_25mhz);
    rx_valid  = v;
    rx_data   = d;
    cmd_ready = r;
  endtask

  task automatic sendstr(input string s, input logic r);
    for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], r);
    cyc(1'b0, 8'd0, r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, r);
  endtask

  task automatic check_log(input string name, input int i, input logic [2:0] op,
                           input logic [7:0] ch, input logic [6:0] x, input logic [4:0] y);
    cmd_t e;
    e = {op, ch, x, y};
    if (i < dut_log.size()) check(name, 32'(dut_log[i]), 32'(e));
    else check(name, 32'hDEAD, 32'(e));
  endtask

  byte unsigned pool[24] = '{8'h1B, "[", "0", "1", "2", "3", "5", "9", ";", "H", "f", "J",
                             "K", "m", "A", "z", 8'h0D, 8'h0A, 8'h08, 8'h7F, 8'h05, 8'hC3, "?", 8'h1B};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3, 1'b1);
    reset = 1'b0;
    check("reset_valid", 32'(cmd_valid), 32'd0);
    check("reset_fields", 32'({cmd_op, cmd_char, cmd_x, cmd_y}), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);

    // Plain characters and C0 controls, with latency pinned.
    dut_log.delete();
    cyc(1'b1, 8'h41, 1'b1);
    cyc(1'b1, 8'h0D, 1'b1);
    check("lat_cycle1", 32'(cmd_valid), 32'd0);
    cyc(1'b1, 8'h0A, 1'b1);
    check("lat_cycle2", 32'(cmd_valid), 32'd1);
    check("lat_char", 32'(cmd_char), 32'h41);
    cyc(1'b1, 8'h08, 1'b1);
    idle(6, 1'b1);
    check("c0_count", 32'(dut_log.size()), 32'd4);
    check_log("put_A", 0, 3'd0, 8'h41, 7'd0, 5'd0);
    check_log("cr", 1, 3'd1, 8'd0, 7'd0, 5'd0);
    check_log("lf", 2, 3'd2, 8'd0, 7'd0, 5'd0);
    check_log("bs", 3, 3'd3, 8'd0, 7'd0, 5'd0);

    // Cursor addressing with clamping and saturation.
    dut_log.delete();
    sendstr("\033[12;40H\033[99;200H\033[H\033[999;5f", 1'b1);
    idle(6, 1'b1);
    check("goto_count", 32'(dut_log.size()), 32'd4);
    check_log("goto_12_40", 0, 3'd4, 8'd0, 7'd39, 5'd11);
    check_log("goto_clamp", 1, 3'd4, 8'd0, 7'd79, 5'd29);
    check_log("goto_home", 2, 3'd4, 8'd0, 7'd0, 5'd0);
    check_log("goto_sat", 3, 3'd4, 8'd0, 7'd4, 5'd29);

    // Clears and sequences that produce nothing.
    dut_log.delete();
    sendstr("\033[2J\033[K\033[1J\033[5m\033xB", 1'b1);
    idle(6, 1'b1);
    check("erase_count", 32'(dut_log.size()), 32'd3);
    check_log("clear", 0, 3'd5, 8'd0, 7'd0, 5'd0);
    check_log("eeol", 1, 3'd6, 8'd0, 7'd0, 5'd0);
    check_log("put_B", 2, 3'd0, 8'h42, 7'd0, 5'd0);

    // Stalled consumer: FIFO fills, sixth byte dropped.
    dut_log.delete();
    sendstr("abcdef", 1'b0);
    check("stall_valid", 32'(cmd_valid), 32'd1);
    check("stall_char", 32'(cmd_char), 32'h61);
    check("stall_ovf", 32'(overflow), 32'd1);
    idle(3, 1'b0);
    check("stall_hold", 32'(cmd_char), 32'h61);
    idle(10, 1'b1);
    check("drain_count", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_log("drain_put", i, 3'd0, 8'(8'h61 + i), 7'd0, 5'd0);
    check("drain_ovf", 32'(overflow), 32'd1);

    // Reset in the middle of a CSI sequence; rx_valid during reset ignored.
    dut_log.delete();
    sendstr("\033[3", 1'b1);
    idle(3, 1'b1);
    @(negedge clk_25mhz);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge clk_25mhz);
    reset = 1'b0; rx_valid = 1'b0;
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    sendstr("\033[2J", 1'b1);
    idle(6, 1'b1);
    check("rst_count", 32'(dut_log.size()), 32'd1);
    check_log("rst_clear", 0, 3'd5, 8'd0, 7'd0, 5'd0);

    // Random bytes against the model with a random consumer.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 23)];
      cyc(1'($urandom_range(0, 2) != 0), b, 1'($urandom_range(0, 9) < 6));
    end
    idle(12, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
